dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder: the target side of the controller's DM_enable/DM_read/DM_write strobes.
- Latches a single-cycle request, waits a programmable number of cycles, then performs the word read or write.
- Signals completion with one-cycle response pulses.
- Sits between the datapath ALU address output and the writeback mux input.

Parameters:
- DATA_W, 32, data word width in bits
- DEPTH, 1024, number of words in the array
- ADDR_W, 10, word-index width; must equal clog2(DEPTH)
- WAIT_CYC, 1, wait cycles inserted between accept and response (0..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- DM_enable  in  1  request qualifier
- DM_read  in  1  read request
- DM_write  in  1  write request
- DM_address  in  32  byte address
- DM_in  in  DATA_W  write data
- DM_out  out  DATA_W  read data; holds the last read value
- DM_busy  out  1  high while a request is outstanding
- DM_rvalid  out  1  one-cycle pulse: DM_out valid
- DM_wdone  out  1  one-cycle pulse: write committed
- DM_err  out  1  one-cycle pulse: illegal request
- DM_ovf  out  1  sticky: a request was dropped while busy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- On rst=0 at a clk edge:
  - state=IDLE, wait counter=0, latched request cleared.
  - DM_out=0, DM_busy=0, DM_rvalid=0, DM_wdone=0, DM_err=0, DM_ovf=0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - A request is sampled when DM_enable=1 and (DM_read|DM_write)=1.
  - The request latches: op, word index = DM_address[ADDR_W+1:2], DM_address[1:0], DM_in.
  - Next state: WAIT if WAIT_CYC>0, otherwise RESP.
  - DM_enable=1 with read=write=0 is ignored.
- WAIT:
  - Counter loads WAIT_CYC-1 on accept and decrements each cycle.
  - At counter=0, the next state is RESP.
- RESP:
  - Lasts exactly one cycle, then returns to IDLE.
  - The following cycle may accept a new request.
- Latency: request sampled at edge T gives a response pulse high during cycle T+1+WAIT_CYC.
- Read: the array is read on the edge entering RESP. DM_out updates on that edge and DM_rvalid=1 during RESP.
- Write: the array is written on the edge entering RESP. DM_wdone=1 during RESP.
- Illegal requests: the response is DM_err=1 in RESP, with no array access and DM_out unchanged. Illegal means any of:
  - DM_read=DM_write=1
  - DM_address[1:0]!=0
  - DM_address[31:ADDR_W+2]!=0
- DM_busy = (state!=IDLE).
- Overflow: a request presented while busy is dropped and sets DM_ovf=1. DM_ovf clears only on reset.
- Reset mid-operation: rst=0 on the edge that would enter RESP has priority. A pending write is not committed and no pulse is produced.
- Exactly one of DM_rvalid/DM_wdone/DM_err is high in RESP. All three are 0 outside RESP.
- Overflow check priority: a request in RESP is also a busy-cycle request and is dropped with DM_ovf set.

Optional Feature:
- Macro: DM_PARITY_EN.
- Defined:
  - The array stores DATA_W+1 bits per word; the extra bit is the even parity of the data, computed at commit.
  - On read, parity is recomputed. On mismatch: DM_err=1 instead of DM_rvalid, and DM_out still updates with the raw data.
  - The bench injects errors through the hierarchical array path.
- Undefined: no parity storage or check; DM_err arises only from illegal requests.

Decomposition:
- Package dm_pkg:
  - state enum (IDLE, WAIT, RESP)
  - op enum (OP_RD, OP_WR, OP_BAD)
  - function word_idx(addr)
  - function addr_legal(addr)
  - parity function under DM_PARITY_EN
- Sub-module dm_array: single-port synchronous array, DEPTH x (DATA_W or DATA_W+1), with ports we, idx, wdata, rdata registered.
- dm_responder holds the FSM, wait counter, request latch and response generation.

Test Plan:
- WAIT_CYC=1: write 0xDEADBEEF to 0x10 -> DM_wdone high exactly 2 cycles after the request edge. Then read 0x10 -> DM_rvalid 2 cycles after its request, with DM_out=0xDEADBEEF.
- WAIT_CYC=0: back-to-back read of 0x0 issued the cycle after RESP -> accepted; DM_rvalid at T+1; DM_ovf stays 0.
- Request during WAIT (read 0x4 while busy) -> dropped, DM_ovf=1 and stays 1; the original response is unaffected.
- Illegal requests: read 0x6, then read+write both high, then address 0x1000 (DEPTH=1024) -> DM_err pulse each, no array change, DM_out unchanged.
- Write 0x12345678 to 0x20, then assert rst=0 on the commit edge -> no DM_wdone. A subsequent read of 0x20 returns the old value and all outputs are 0 after reset.
- DM_PARITY_EN: write 0xA5 to 0x8, flip the stored parity bit, read 0x8 -> DM_err=1, DM_rvalid=0, DM_out=0xA5.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and address helpers for the data-memory responder.
// DM_PARITY_EN adds the even-parity helper used by the parity-protected array.
package dm_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD} op_t;

  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  // Word aligned and no bits set above the array's index range.
  function automatic logic addr_legal(input logic [31:0] addr, input int addr_w);
    return (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
  endfunction

`ifdef DM_PARITY_EN
  localparam int DM_MAX_W = 64;

  function automatic logic even_par(input logic [DM_MAX_W-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/dm_array.sv
// Single-port word array with registered read data; contents are never reset.
module dm_array #(
  parameter int W      = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one strobe, waits WAIT_CYC cycles, then reads or writes.
// Optional DM_PARITY_EN stores an even-parity bit per word and flags mismatches on DM_err.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_enable,
  input  logic              DM_read,
  input  logic              DM_write,
  input  logic [31:0]       DM_address,
  input  logic [DATA_W-1:0] DM_in,
  output logic [DATA_W-1:0] DM_out,
  output logic              DM_busy,
  output logic              DM_rvalid,
  output logic              DM_wdone,
  output logic              DM_err,
  output logic              DM_ovf
);

`ifdef DM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t            state, state_nxt;
  op_t               op_dec, op_cur, op_p0;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_dec, idx_cur, idx_p0;
  logic [DATA_W-1:0] wdata_cur, wdata_p0, dout_p1;
  logic              ovf_q;
  logic              req, accept, enter_resp, resp_rd, par_err;
  logic              arr_we;
  logic [MEM_W-1:0]  arr_wdata, arr_rdata;

  assign req        = DM_enable & (DM_read | DM_write);
  assign accept     = req & (state == IDLE);
  assign enter_resp = rst & (state_nxt == RESP);
  assign idx_dec    = ADDR_W'(word_idx(DM_address));

  always_comb begin
    op_dec = OP_WR;
    if ((DM_read & DM_write) | ~addr_legal(DM_address, ADDR_W)) op_dec = OP_BAD;
    else if (DM_read)                                              op_dec = OP_RD;
  end

  // With WAIT_CYC=0 the access happens on the accept edge, before the latch holds the request.
  assign op_cur    = (state == IDLE) ? op_dec  : op_p0;
  assign idx_cur   = (state == IDLE) ? idx_dec : idx_p0;
  assign wdata_cur = (state == IDLE) ? DM_in   : wdata_p0;
  assign arr_we    = enter_resp & (op_cur == OP_WR);

`ifdef DM_PARITY_EN
  assign arr_wdata = {even_par(DM_MAX_W'(wdata_cur)), wdata_cur};
  assign par_err   = arr_rdata[DATA_W] != even_par(DM_MAX_W'(arr_rdata[DATA_W-1:0]));
`else
  assign arr_wdata = wdata_cur;
  assign par_err   = 1'b0;
`endif

  dm_array #(.W(MEM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (idx_cur),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (WAIT_CYC > 0) ? WAIT : RESP;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request latch and wait counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= 4'd0;
      op_p0    <= OP_RD;
      idx_p0   <= '0;
      wdata_p0 <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= CNT_LOAD;
        op_p0    <= op_dec;
        idx_p0   <= idx_dec;
        wdata_p0 <= DM_in;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (req && state != IDLE) ovf_q <= 1'b1;
    end
  end

  // Stage p1: hold the last read word once RESP ends
  assign resp_rd = (state == RESP) && (op_p0 == OP_RD);

  always_ff @(posedge clk) begin
    if (!rst)        dout_p1 <= '0;
    else if (resp_rd) dout_p1 <= arr_rdata[DATA_W-1:0];
  end

  always_comb begin
    DM_out    = resp_rd ? arr_rdata[DATA_W-1:0] : dout_p1;
    DM_busy   = (state != IDLE);
    DM_rvalid = resp_rd & ~par_err;
    DM_wdone  = (state == RESP) && (op_p0 == OP_WR);
    DM_err    = ((state == RESP) && (op_p0 == OP_BAD)) | (resp_rd & par_err);
    DM_ovf    = ovf_q;
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with WAIT_CYC=1, one with WAIT_CYC=0.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en1, en0, rd, wr;
  logic [31:0] addr, din;
  logic [31:0] out1, out0;
  logic        busy1, rv1, wd1, err1, ovf1;
  logic        busy0, rv0, wd0, err0, ovf0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.DATA_W(32), .DEPTH(1024), .ADDR_W(10), .WAIT_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .DM_enable(en1), .DM_read(rd), .DM_write(wr),
    .DM_address(addr), .DM_in(din), .DM_out(out1), .DM_busy(busy1),
    .DM_rvalid(rv1), .DM_wdone(wd1), .DM_err(err1), .DM_ovf(ovf1)
  );

  dm_responder #(.DATA_W(32), .DEPTH(1024), .ADDR_W(10), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .DM_enable(en0), .DM_read(rd), .DM_write(wr),
    .DM_address(addr), .DM_in(din), .DM_out(out0), .DM_busy(busy0),
    .DM_rvalid(rv0), .DM_wdone(wd0), .DM_err(err0), .DM_ovf(ovf0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s1, input logic s0, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    en1 = s1; en0 = s0; rd = r; wr = w; addr = a; din = d;
  endtask

  // Present a request for one sampling edge; returns 1ns after that edge.
  task automatic issue(input logic s1, input logic s0, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(s1, s0, r, w, a, d);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // WAIT_CYC=1 response: one busy wait cycle, the RESP cycle, then idle.
  task automatic resp1(input string tag, input logic [3:0] flags, input logic [31:0] exp_out);
    @(negedge clk);
    check({tag, "_wait"}, {busy1, rv1, wd1, err1}, 4'b1000);
    @(negedge clk);
    check({tag, "_resp"}, {busy1, rv1, wd1, err1}, flags);
    check({tag, "_out"}, out1, exp_out);
    @(negedge clk);
    check({tag, "_idle"}, {busy1, rv1, wd1, err1}, 4'b0000);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_flags1", {busy1, rv1, wd1, err1, ovf1}, 5'b0);
    check("rst_out1", out1, 32'h0);
    check("rst_flags0", {busy0, rv0, wd0, err0, ovf0}, 5'b0);
    rst = 1'b1;

    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    resp1("wr10", 4'b1010, 32'h0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    resp1("rd10", 4'b1100, 32'hDEADBEEF);

    // Requests during WAIT and during RESP are both dropped.
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    check("ovf_wait_flags", {busy1, rv1, wd1, err1}, 4'b1000);
    check("ovf_before", ovf1, 1'b0);
    @(negedge clk);
    check("ovf_resp_flags", {busy1, rv1, wd1, err1}, 4'b1100);
    check("ovf_resp_out", out1, 32'hDEADBEEF);
    check("ovf_set", ovf1, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("ovf_dropped", {busy1, rv1, wd1, err1}, 4'b0000);
    check("ovf_sticky", ovf1, 1'b1);

    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
    resp1("bad_align", 4'b1001, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h11111111);
    resp1("bad_rdwr", 4'b1001, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
    resp1("bad_range", 4'b1001, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h1010, 32'h22222222);
    resp1("bad_range_wr", 4'b1001, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    resp1("rd10_intact", 4'b1100, 32'hDEADBEEF);

    // Reset lands on the commit edge of a pending write.
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D);
    resp1("wr20_old", 4'b1010, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_flags", {busy1, rv1, wd1, err1, ovf1}, 5'b0);
    check("rstmid_out", out1, 32'h0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    resp1("rd20_old", 4'b1100, 32'h0BADF00D);

    // Zero-wait instance: back-to-back accept the cycle after RESP.
    issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
    @(negedge clk);
    check("w0_wr_resp", {busy0, rv0, wd0, err0}, 4'b1010);
    @(posedge clk);
    #1;
    check("w0_idle", busy0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("w0_rd_resp", {busy0, rv0, wd0, err0}, 4'b1100);
    check("w0_rd_out", out0, 32'hCAFEF00D);
    check("w0_ovf", ovf0, 1'b0);
    @(negedge clk);
    check("w0_hold_out", out0, 32'hCAFEF00D);
    check("w0_after", {busy0, rv0, wd0, err0}, 4'b0000);

`ifdef DM_PARITY_EN
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h000000A5);
    resp1("par_wr", 4'b1010, 32'h0BADF00D);
    u_dut1.u_array.mem[2][32] = ~u_dut1.u_array.mem[2][32];
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    resp1("par_rd", 4'b1001, 32'h000000A5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
